// File: rtl/dispatch_ctrl.sv
// rtl/dispatch_ctrl.sv - dual-issue in-order dispatch with scoreboard and RS credits (optional stats: DISPATCH_STATS_EN)
module dispatch_ctrl #(
  parameter int ALU_RS_DEPTH = 4,
  parameter int MEM_RS_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst1,
  input  logic        inst_vld1,
  input  logic [31:0] inst2,
  input  logic        inst_vld2,
  output logic        stall1,
  output logic        stall2,
  output logic        disp_vld1,
  output logic [31:0] disp_inst1,
  output logic        disp_vld2,
  output logic [31:0] disp_inst2,
  input  logic        alu_free,
  input  logic        mem_free,
  input  logic        wb1_vld,
  input  logic [4:0]  wb1_reg,
  input  logic        wb2_vld,
  input  logic [4:0]  wb2_reg,
  input  logic        flush
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0] cnt_dual,
  output logic [31:0] cnt_single,
  output logic [31:0] cnt_zero
`endif
);

  localparam logic [3:0] ALU_DEPTH = 4'(ALU_RS_DEPTH);
  localparam logic [3:0] MEM_DEPTH = 4'(MEM_RS_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LOAD  = 6'h23;
  localparam logic [5:0] OP_STORE = 6'h2B;

  typedef struct packed {
    logic       is_mem;
    logic       has_dst;
    logic [4:0] dst;
    logic [4:0] src1;
    logic       has_src2;
    logic [4:0] src2;
  } dec_t;

  // Register fields and class of one instruction; a zero destination is
  // dropped here so r0 can never be marked busy or create a dependency.
  function automatic dec_t decode(input logic [31:0] inst);
    dec_t d;
    d.is_mem   = 1'b0;
    d.has_dst  = 1'b1;
    d.dst      = inst[15:11];
    d.src1     = inst[25:21];
    d.has_src2 = 1'b1;
    d.src2     = inst[20:16];
    case (inst[31:26])
      OP_RTYPE: begin
      end
      OP_LOAD: begin
        d.is_mem   = 1'b1;
        d.dst      = inst[20:16];
        d.has_src2 = 1'b0;
      end
      OP_STORE: begin
        d.is_mem  = 1'b1;
        d.has_dst = 1'b0;
      end
      default: begin
        d.dst      = inst[20:16];
        d.has_src2 = 1'b0;
      end
    endcase
    if (d.dst == 5'd0) d.has_dst = 1'b0;
    return d;
  endfunction

  // RAW on either source or WAW on the destination against the registered scoreboard.
  function automatic logic sb_hazard(input logic [31:0] sb, input dec_t d);
    return sb[d.src1] | (d.has_src2 & sb[d.src2]) | (d.has_dst & sb[d.dst]);
  endfunction

  // Saturating credit update: credit - dispatched + freed, capped at depth.
  function automatic logic [3:0] credit_next(input logic [3:0] cr, input logic [1:0] used,
                                             input logic freed, input logic [3:0] depth);
    logic [4:0] sum;
    sum = {1'b0, cr} + {4'd0, freed} - {3'd0, used};
    if (sum > {1'b0, depth}) return depth;
    return sum[3:0];
  endfunction

  logic [31:0] sb_q, sb_d;
  logic [3:0]  alu_cr_q, alu_cr_d;
  logic [3:0]  mem_cr_q, mem_cr_d;
  logic        disp_vld1_q, disp_vld1_d;
  logic        disp_vld2_q, disp_vld2_d;
  logic [31:0] disp_inst1_q, disp_inst1_d;
  logic [31:0] disp_inst2_q, disp_inst2_d;

  dec_t       d1, d2;
  logic       ok1, ok2;
  logic       cr1_ok, cr2_ok, pair_dep;
  logic [1:0] alu_used, mem_used;
  logic [31:0] sb_set, sb_clr;

  // Issue decision for both slots from decode, scoreboard and credits.
  always_comb begin
    d1 = decode(inst1);
    d2 = decode(inst2);

    cr1_ok = d1.is_mem ? (mem_cr_q != 4'd0) : (alu_cr_q != 4'd0);
    if (d2.is_mem == d1.is_mem)
      cr2_ok = d2.is_mem ? (mem_cr_q >= 4'd2) : (alu_cr_q >= 4'd2);
    else
      cr2_ok = d2.is_mem ? (mem_cr_q != 4'd0) : (alu_cr_q != 4'd0);

    pair_dep = d1.has_dst & ((d2.src1 == d1.dst) |
                             (d2.has_src2 & (d2.src2 == d1.dst)) |
                             (d2.has_dst & (d2.dst == d1.dst)));

    ok1 = ~rst & inst_vld1 & ~flush & ~sb_hazard(sb_q, d1) & cr1_ok;
    ok2 = ok1 & inst_vld2 & ~sb_hazard(sb_q, d2) & cr2_ok & ~pair_dep;
  end

  assign stall1 = ~ok1;
  assign stall2 = ~ok2;

  // Next state for scoreboard, credits and dispatch slots; flush clears
  // tracking and drops that cycle's releases and writebacks.
  always_comb begin
    sb_set = 32'd0;
    sb_clr = 32'd0;
    if (ok1 && d1.has_dst) sb_set[d1.dst] = 1'b1;
    if (ok2 && d2.has_dst) sb_set[d2.dst] = 1'b1;
    if (wb1_vld) sb_clr[wb1_reg] = 1'b1;
    if (wb2_vld) sb_clr[wb2_reg] = 1'b1;

    alu_used = {1'b0, ok1 & ~d1.is_mem} + {1'b0, ok2 & ~d2.is_mem};
    mem_used = {1'b0, ok1 &  d1.is_mem} + {1'b0, ok2 &  d2.is_mem};

    if (flush) begin
      sb_d     = 32'd0;
      alu_cr_d = ALU_DEPTH;
      mem_cr_d = MEM_DEPTH;
    end else begin
      sb_d     = ((sb_q & ~sb_clr) | sb_set) & 32'hFFFF_FFFE;
      alu_cr_d = credit_next(alu_cr_q, alu_used, alu_free, ALU_DEPTH);
      mem_cr_d = credit_next(mem_cr_q, mem_used, mem_free, MEM_DEPTH);
    end

    disp_vld1_d  = ok1;
    disp_vld2_d  = ok2;
    disp_inst1_d = ok1 ? inst1 : disp_inst1_q;
    disp_inst2_d = ok2 ? inst2 : disp_inst2_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q         <= 32'd0;
      alu_cr_q     <= ALU_DEPTH;
      mem_cr_q     <= MEM_DEPTH;
      disp_vld1_q  <= 1'b0;
      disp_vld2_q  <= 1'b0;
      disp_inst1_q <= 32'd0;
      disp_inst2_q <= 32'd0;
    end else begin
      sb_q         <= sb_d;
      alu_cr_q     <= alu_cr_d;
      mem_cr_q     <= mem_cr_d;
      disp_vld1_q  <= disp_vld1_d;
      disp_vld2_q  <= disp_vld2_d;
      disp_inst1_q <= disp_inst1_d;
      disp_inst2_q <= disp_inst2_d;
    end
  end

  assign disp_vld1  = disp_vld1_q;
  assign disp_vld2  = disp_vld2_q;
  assign disp_inst1 = disp_inst1_q;
  assign disp_inst2 = disp_inst2_q;

`ifdef DISPATCH_STATS_EN
  logic [31:0] cnt_dual_q, cnt_dual_d;
  logic [31:0] cnt_single_q, cnt_single_d;
  logic [31:0] cnt_zero_q, cnt_zero_d;

  // Bucket every cycle with a valid oldest instruction by how many dispatched.
  always_comb begin
    cnt_dual_d   = cnt_dual_q;
    cnt_single_d = cnt_single_q;
    cnt_zero_d   = cnt_zero_q;
    if (inst_vld1) begin
      if (ok2)      cnt_dual_d   = cnt_dual_q + 32'd1;
      else if (ok1) cnt_single_d = cnt_single_q + 32'd1;
      else          cnt_zero_d   = cnt_zero_q + 32'd1;
    end
  end

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_dual_q   <= 32'd0;
      cnt_single_q <= 32'd0;
      cnt_zero_q   <= 32'd0;
    end else begin
      cnt_dual_q   <= cnt_dual_d;
      cnt_single_q <= cnt_single_d;
      cnt_zero_q   <= cnt_zero_d;
    end
  end

  assign cnt_dual   = cnt_dual_q;
  assign cnt_single = cnt_single_q;
  assign cnt_zero   = cnt_zero_q;
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb/tb_dispatch_ctrl.sv - directed self-checking bench for dispatch_ctrl
module tb_dispatch_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst1, inst2;
  logic        inst_vld1, inst_vld2;
  logic        stall1, stall2;
  logic        disp_vld1, disp_vld2;
  logic [31:0] disp_inst1, disp_inst2;
  logic        alu_free, mem_free;
  logic        wb1_vld, wb2_vld;
  logic [4:0]  wb1_reg, wb2_reg;
  logic        flush;
`ifdef DISPATCH_STATS_EN
  logic [31:0] cnt_dual, cnt_single, cnt_zero;
`endif

  int checks = 0;
  int failures = 0;

  dispatch_ctrl #(.ALU_RS_DEPTH(4), .MEM_RS_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .inst1(inst1), .inst_vld1(inst_vld1), .inst2(inst2), .inst_vld2(inst_vld2),
    .stall1(stall1), .stall2(stall2),
    .disp_vld1(disp_vld1), .disp_inst1(disp_inst1),
    .disp_vld2(disp_vld2), .disp_inst2(disp_inst2),
    .alu_free(alu_free), .mem_free(mem_free),
    .wb1_vld(wb1_vld), .wb1_reg(wb1_reg), .wb2_vld(wb2_vld), .wb2_reg(wb2_reg),
    .flush(flush)
`ifdef DISPATCH_STATS_EN
    , .cnt_dual(cnt_dual), .cnt_single(cnt_single), .cnt_zero(cnt_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 11'h020};
  endfunction
  function automatic logic [31:0] lw(input logic [4:0] rt, input logic [4:0] rs);
    return {6'h23, rs, rt, 16'h0000};
  endfunction
  function automatic logic [31:0] sw(input logic [4:0] rt, input logic [4:0] rs);
    return {6'h2B, rs, rt, 16'h0000};
  endfunction

  task automatic set_in(input logic [31:0] a, input logic va, input logic [31:0] b, input logic vb);
    inst1 = a; inst_vld1 = va; inst2 = b; inst_vld2 = vb;
  endtask

  task automatic wb(input logic v1, input logic [4:0] r1, input logic v2, input logic [4:0] r2);
    wb1_vld = v1; wb1_reg = r1; wb2_vld = v2; wb2_reg = r2;
  endtask

  // Advance past the next edge and return side-band pulses to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    alu_free = 1'b0; mem_free = 1'b0; flush = 1'b0;
    wb(1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  localparam logic [31:0] I_A = 32'h0022_1820;
  localparam logic [31:0] I_B = 32'h0085_2020;
  localparam logic [31:0] I_C = 32'h0061_1020;

  initial begin
    rst = 1'b1; flush = 1'b0; alu_free = 1'b0; mem_free = 1'b0;
    wb(1'b0, 5'd0, 1'b0, 5'd0);
    set_in(32'd0, 1'b0, 32'd0, 1'b0);
    tick();

    set_in(I_A, 1'b1, I_B, 1'b1);
    #1;
    check("rst_stall1", 32'(stall1), 32'd1);
    check("rst_stall2", 32'(stall2), 32'd1);
    tick();
    check("rst_vld1", 32'(disp_vld1), 32'd0);
    check("rst_vld2", 32'(disp_vld2), 32'd0);
    check("rst_inst1", disp_inst1, 32'd0);
    check("rst_inst2", disp_inst2, 32'd0);
`ifdef DISPATCH_STATS_EN
    check("rst_cnt_dual", cnt_dual, 32'd0);
`endif
    rst = 1'b0;

    set_in(I_A, 1'b1, I_B, 1'b1);
    #1;
    check("pair_stall1", 32'(stall1), 32'd0);
    check("pair_stall2", 32'(stall2), 32'd0);
    tick();
    check("pair_vld1", 32'(disp_vld1), 32'd1);
    check("pair_vld2", 32'(disp_vld2), 32'd1);
    check("pair_inst1", disp_inst1, I_A);
    check("pair_inst2", disp_inst2, I_B);

    set_in(I_C, 1'b1, 32'd0, 1'b0);
    #1 check("sb_r3_busy", 32'(stall1), 32'd1);
    set_in(r_add(5'd9, 5'd4, 5'd0), 1'b1, 32'd0, 1'b0);
    #1 check("sb_r4_busy", 32'(stall1), 32'd1);
    set_in(I_C, 1'b1, 32'd0, 1'b0);
    wb(1'b1, 5'd3, 1'b1, 5'd4);
    #1 check("wb_no_bypass", 32'(stall1), 32'd1);
    tick();
    check("stall_vld1", 32'(disp_vld1), 32'd0);
    check("stall_hold_inst1", disp_inst1, I_A);

    set_in(I_C, 1'b1, 32'd0, 1'b0);
    #1;
    check("after_wb_stall1", 32'(stall1), 32'd0);
    check("no_vld2_stall2", 32'(stall2), 32'd1);
    tick();
    check("after_wb_vld1", 32'(disp_vld1), 32'd1);
    check("after_wb_inst1", disp_inst1, I_C);

    set_in(32'd0, 1'b0, 32'd0, 1'b0);
    wb(1'b1, 5'd2, 1'b0, 5'd0);
    alu_free = 1'b1;
    #1 check("no_valid_stall1", 32'(stall1), 32'd1);
    tick();

    set_in(r_add(5'd3, 5'd1, 5'd5), 1'b1, I_C, 1'b1);
    #1;
    check("intra_raw_stall1", 32'(stall1), 32'd0);
    check("intra_raw_stall2", 32'(stall2), 32'd1);
    tick();
    check("intra_raw_vld2", 32'(disp_vld2), 32'd0);

    set_in(I_C, 1'b1, 32'd0, 1'b0);
    wb(1'b1, 5'd3, 1'b1, 5'd3);
    #1 check("reissue_wait", 32'(stall1), 32'd1);
    tick();
    set_in(I_C, 1'b1, 32'd0, 1'b0);
    wb(1'b0, 5'd0, 1'b1, 5'd2);
    #1 check("reissue_go", 32'(stall1), 32'd0);
    tick();
    check("reissue_inst1", disp_inst1, I_C);

    set_in(lw(5'd11, 5'd2), 1'b1, 32'd0, 1'b0);
    #1 check("set_wins", 32'(stall1), 32'd1);
    set_in(r_add(5'd10, 5'd0, 5'd0), 1'b1, 32'd0, 1'b0);
    #1 check("alu_credit0", 32'(stall1), 32'd1);
    wb(1'b1, 5'd2, 1'b0, 5'd0);
    tick();

    set_in(lw(5'd6, 5'd0), 1'b1, lw(5'd7, 5'd0), 1'b1);
    #1 check("mem_pair_stall2", 32'(stall2), 32'd0);
    tick();
    set_in(lw(5'd8, 5'd0), 1'b1, 32'd0, 1'b0);
    #1 check("mem_credit0", 32'(stall1), 32'd1);
    tick();
    mem_free = 1'b1;
    #1 check("mem_free_registered", 32'(stall1), 32'd1);
    tick();
    mem_free = 1'b1;
    #1 check("mem_credit1", 32'(stall1), 32'd0);
    tick();
    check("mem_disp_inst1", disp_inst1, lw(5'd8, 5'd0));

    set_in(sw(5'd9, 5'd0), 1'b1, sw(5'd10, 5'd0), 1'b1);
    #1;
    check("mem_net_zero", 32'(stall1), 32'd0);
    check("mem_pair_credit", 32'(stall2), 32'd1);
    tick();

    set_in(lw(5'd11, 5'd0), 1'b1, 32'd0, 1'b0);
    flush = 1'b1; alu_free = 1'b1; mem_free = 1'b1;
    wb(1'b1, 5'd6, 1'b0, 5'd0);
    #1 check("flush_stall1", 32'(stall1), 32'd1);
    tick();
    check("flush_vld1", 32'(disp_vld1), 32'd0);
    check("flush_vld2", 32'(disp_vld2), 32'd0);

    set_in(r_add(5'd12, 5'd6, 5'd7), 1'b1, r_add(5'd13, 5'd8, 5'd0), 1'b1);
    #1;
    check("post_flush_stall1", 32'(stall1), 32'd0);
    check("post_flush_stall2", 32'(stall2), 32'd0);
    tick();

    set_in(32'd0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      alu_free = 1'b1;
      tick();
    end

    set_in(r_add(5'd14, 5'd0, 5'd0), 1'b1, r_add(5'd14, 5'd0, 5'd0), 1'b1);
    #1 check("intra_waw", 32'(stall2), 32'd1);
    set_in(r_add(5'd14, 5'd0, 5'd0), 1'b1, r_add(5'd15, 5'd0, 5'd0), 1'b1);
    #1 check("indep_pair2", 32'(stall2), 32'd0);
    tick();
    set_in(r_add(5'd16, 5'd0, 5'd0), 1'b1, r_add(5'd17, 5'd0, 5'd0), 1'b1);
    #1 check("alu_last_two", 32'(stall2), 32'd0);
    tick();
    set_in(r_add(5'd18, 5'd0, 5'd0), 1'b1, 32'd0, 1'b0);
    #1 check("alu_saturate", 32'(stall1), 32'd1);
    tick();
    alu_free = 1'b1;
    tick();
    set_in(r_add(5'd18, 5'd0, 5'd0), 1'b1, r_add(5'd19, 5'd0, 5'd0), 1'b1);
    #1;
    check("alu_one_credit1", 32'(stall1), 32'd0);
    check("alu_pair_credit", 32'(stall2), 32'd1);
    tick();
    check("alu_one_vld1", 32'(disp_vld1), 32'd1);

    rst = 1'b1;
    set_in(r_add(5'd20, 5'd0, 5'd0), 1'b1, r_add(5'd21, 5'd0, 5'd0), 1'b1);
    alu_free = 1'b1;
    #1 check("midrst_stall1", 32'(stall1), 32'd1);
    tick();
    check("midrst_vld1", 32'(disp_vld1), 32'd0);
    check("midrst_inst1", disp_inst1, 32'd0);
    check("midrst_inst2", disp_inst2, 32'd0);
`ifdef DISPATCH_STATS_EN
    check("midrst_cnt_single", cnt_single, 32'd0);
    check("midrst_cnt_zero", cnt_zero, 32'd0);
`endif
    rst = 1'b0;

    set_in(r_add(5'd20, 5'd12, 5'd18), 1'b1, r_add(5'd21, 5'd19, 5'd13), 1'b1);
    #1;
    check("post_rst_stall1", 32'(stall1), 32'd0);
    check("post_rst_stall2", 32'(stall2), 32'd0);
    tick();
    check("post_rst_vld2", 32'(disp_vld2), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
